// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall patterns,
// stage bit positions and the multi-cycle sequencer state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // Stage bit positions within the stall vector
    localparam int StgPc  = 0;
    localparam int StgIf  = 1;
    localparam int StgId  = 2;
    localparam int StgEx  = 3;
    localparam int StgMem = 4;
    localparam int StgWb  = 5;

    localparam logic [STALL_W-1:0] StallNone   = 6'b000000;
    localparam logic [STALL_W-1:0] StallFromId = 6'b000111;
    localparam logic [STALL_W-1:0] StallFromEx = 6'b001111;

    typedef enum logic {
        McIdle = 1'b0,
        McRun  = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests, sequences
// multi-cycle EX ops with a countdown, and counts stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_len,
    input  logic              flush,
    output logic [5:0]        stall,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] stall_cycles
);

    mc_state_e        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             mc_stall;
    logic             done_raw;
    logic [5:0]       stall_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= McIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // The start cycle is itself a stalled EX cycle, hence the L-2 preload.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        mc_stall = 1'b0;
        done_raw = 1'b0;
        if (flush) begin
            state_n = McIdle;
            cnt_n   = '0;
        end else begin
            case (state_q)
                McIdle: begin
                    if (mc_start) begin
                        if (mc_len >= CNT_W'(2)) begin
                            mc_stall = 1'b1;
                            cnt_n    = mc_len - CNT_W'(2);
                            state_n  = McRun;
                        end else begin
                            done_raw = 1'b1;
                        end
                    end
                end
                McRun: begin
                    if (cnt_q != '0) begin
                        mc_stall = 1'b1;
                        cnt_n    = cnt_q - CNT_W'(1);
                    end else begin
                        done_raw = 1'b1;
                        state_n  = McIdle;
                    end
                end
                default: begin
                    state_n = McIdle;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_raw = StallNone;
        if (flush)
            stall_raw = StallNone;
        else if (stallreq_ex || mc_stall)
            stall_raw = StallFromEx;
        else if (stallreq_id)
            stall_raw = StallFromId;
    end

    // Outputs are forced quiet for the whole time reset is held low.
    assign stall   = rst ? stall_raw : StallNone;
    assign mc_done = rst & done_raw;
    assign mc_busy = rst & (state_q == McRun);

    pipe_ctrl_sat_counter #(
        .W (PERF_W)
    ) u_perf (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall[StgPc]),
        .clear (1'b0),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations; a narrow
// performance counter makes saturation reachable in a few cycles.
module tb_pipe_ctrl;

    localparam int CNT_W  = 6;
    localparam int PERF_W = 4;

    logic              clk;
    logic              rst;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_len;
    logic              flush;
    logic [5:0]        stall;
    logic              mc_busy;
    logic              mc_done;
    logic [PERF_W-1:0] stall_cycles;

    int n_cmp;
    int n_bad;

    pipe_ctrl #(
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mc_start     (mc_start),
        .mc_len       (mc_len),
        .flush        (flush),
        .stall        (stall),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs shortly after a rising edge, then let them settle.
    task automatic drive(input logic id, input logic ex, input logic st,
                         input logic [CNT_W-1:0] len, input logic fl);
        stallreq_id = id;
        stallreq_ex = ex;
        mc_start    = st;
        mc_len      = len;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] s, input logic b, input logic d);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".busy"}, 32'(mc_busy), 32'(b));
        chk({tag, ".done"}, 32'(mc_done), 32'(d));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #12;
        chk("rst.cnt", 32'(stall_cycles), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 6'd1, 1'b0);
        chk_out("rst.quiet", 6'b000000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();

        // single ID stall
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk_out("id", 6'b000111, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("id.cnt", 32'(stall_cycles), 32'd1);
        chk("id.after", 32'(stall), 32'd0);

        // L=4 multi-cycle op, EX keeps asserting mc_start while held
        drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
        chk_out("l4.c1", 6'b001111, 1'b0, 1'b0);
        tick();
        chk_out("l4.c2", 6'b001111, 1'b1, 1'b0);
        tick();
        chk_out("l4.c3", 6'b001111, 1'b1, 1'b0);
        tick();
        chk_out("l4.c4", 6'b000000, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk_out("l4.c5", 6'b000000, 1'b0, 1'b0);
        chk("l4.cnt", 32'(stall_cycles), 32'd4);

        // short ops complete immediately
        drive(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
        chk_out("l1", 6'b000000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        chk_out("l0", 6'b000000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk_out("l0.after", 6'b000000, 1'b0, 1'b0);
        chk("l01.cnt", 32'(stall_cycles), 32'd4);

        // L=5 flushed in cycle 3, then a fresh L=2 op
        drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
        chk_out("fl.c1", 6'b001111, 1'b0, 1'b0);
        tick();
        chk_out("fl.c2", 6'b001111, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 6'd5, 1'b1);
        chk_out("fl.c3", 6'b000000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        chk_out("fl.c4", 6'b001111, 1'b0, 1'b0);
        tick();
        chk_out("fl.c5", 6'b000000, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk_out("fl.c6", 6'b000000, 1'b0, 1'b0);
        chk("fl.cnt", 32'(stall_cycles), 32'd7);

        // ID request concurrent with an L=3 op
        drive(1'b1, 1'b0, 1'b1, 6'd3, 1'b0);
        chk_out("mix.c1", 6'b001111, 1'b0, 1'b0);
        tick();
        chk_out("mix.c2", 6'b001111, 1'b1, 1'b0);
        tick();
        chk_out("mix.c3", 6'b000111, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("mix.cnt", 32'(stall_cycles), 32'd10);

        // async reset in the middle of an L=6 op
        drive(1'b0, 1'b0, 1'b1, 6'd6, 1'b0);
        tick();
        chk_out("ar.c2", 6'b001111, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk_out("ar.asserted", 6'b000000, 1'b0, 1'b0);
        chk("ar.cnt", 32'(stall_cycles), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("ar.after", 6'b000000, 1'b0, 1'b0);

        // saturation of the 4-bit counter under a continuous EX stall
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        chk("sat.14", 32'(stall_cycles), 32'd14);
        tick();
        chk("sat.15", 32'(stall_cycles), 32'd15);
        for (int i = 0; i < 3; i++) tick();
        chk("sat.hold", 32'(stall_cycles), 32'd15);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("flush.prio", 32'(stall), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Pipeline stall controller: the producer of the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Merges single-cycle stall requests from ID and EX.
- Sequences multi-cycle EX operations (multiply-accumulate, iterative divide) with an internal countdown, then pulses completion back to EX.
- Keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 6, width of the multi-cycle length input and internal countdown
- PERF_W, 32, width of the stall-cycle counter

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset (one clock; reset is asynchronous and active-low)
- stallreq_id  input  1  ID requests a one-cycle stall (load-use hazard)
- stallreq_ex  input  1  EX requests a one-cycle stall
- mc_start  input  1  EX presents a multi-cycle op this cycle
- mc_len  input  CNT_W  total EX cycles of that op, L
- flush  input  1  abort any multi-cycle op and drop all stalls
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage
- mc_busy  output  1  multi-cycle op in progress
- mc_done  output  1  single-cycle pulse: EX result is valid this cycle
- stall_cycles  output  PERF_W  saturating count of cycles with stall[0]=1

## Operation
FSM states:
- IDLE
- MC_RUN: holds a countdown `cnt`

IDLE:
- mc_start && L>=2: internal mc_stall=1 this cycle; cnt<=L-2; next state MC_RUN.
- mc_start && L<2: mc_done=1 this cycle; no stall; stay IDLE.
- mc_start=0: no action.

MC_RUN:
- cnt!=0: mc_stall=1; cnt<=cnt-1.
- cnt==0: mc_stall=0; mc_done=1; next state IDLE.
- mc_start is ignored: the held EX instruction keeps asserting it, including in the release cycle.

Stall merge, in priority order:
- flush=1: stall=6'b000000.
- else stallreq_ex || mc_stall: stall=6'b001111.
- else stallreq_id: stall=6'b000111.
- else stall=6'b000000.

Flush:
- Forces next state IDLE and cnt<=0.
- mc_done=0 in the flush cycle, even if cnt==0.
- mc_start in the same cycle as flush is ignored.

Other outputs:
- mc_busy = (state==MC_RUN).
- stall_cycles increments when stall[0]=1 and holds at its maximum value.

## Timing
- stall, mc_done and mc_busy are combinational from the current state and inputs; zero-cycle latency.
- State, cnt and stall_cycles update on posedge clk.
- An op with length L produces exactly L-1 stalled cycles; mc_done falls in cycle L, where the start cycle is cycle 1.
- Reset (async, rst=0): state=IDLE, cnt=0, stall_cycles=0.
- While rst=0, stall=0, mc_busy=0 and mc_done=0 regardless of inputs.
- Reset asserted mid-op abandons the op; no mc_done is produced.
- stallreq_id during MC_RUN is subsumed by the EX pattern.
- The ID request is re-evaluated once the EX stall releases.
- Countdown uses CNT_W bits; L is at most 2^CNT_W-1, and values of L never wrap the countdown.

## Structure
Added to defines.v:
- Stall patterns: StallNone 6'b000000, StallFromId 6'b000111, StallFromEx 6'b001111.
- State encodings: McIdle, McRun.
- Stage bit indices.

Sub-modules:
- None required; the whole block is a single module.
- The saturating counter may optionally be factored as sat_counter (parameter W, inputs inc and clear).

## Test plan
- Reset then idle; stallreq_id=1 for one cycle -> stall=000111 that cycle, stall_cycles=1.
- mc_start, L=4 -> stall=001111 for 3 cycles, mc_busy=1 in cycles 2-4, mc_done=1 in cycle 4 only, then stall=0 and stall_cycles=3.
- mc_start, L=1 and L=0 -> mc_done=1 in the same cycle, no stall, state stays IDLE.
- mc_start, L=5, flush in cycle 3 -> stall=0 in cycle 3, no mc_done, IDLE in cycle 4; a fresh mc_start with L=2 in cycle 4 stalls one cycle.
- stallreq_id held with a concurrent L=3 op -> 001111 in cycles 1-2, 000111 in cycle 3; a mid-op async rst -> all outputs 0 immediately and the counter clears.
- Force stall_cycles to its maximum value and hold stall -> the counter stays at its maximum value.
